// File: rtl/rca_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder made of chained full-adder cells.
module nibble_adder
  import rca_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  logic w_c;

  always_comb begin
    Sum = '0;
    w_c = Cin;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      Sum[i] = A[i] ^ B[i] ^ w_c;
      w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
    end
    Cout = w_c;
  end

endmodule

// File: rtl/rca_sequencer.sv
// Nibble-serial add/subtract controller: one shared 4-bit adder slice, LSB nibble first,
// carry registered between slices, valid/ready on both operand and result sides.
module rca_sequencer
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_opa, r_opb, r_sum;
  logic                 r_carry, r_cout, r_ovf;
  logic [IDX_W-1:0]     r_idx;
  logic [NIBBLE_W-1:0]  w_a_nib, w_b_nib, w_s_nib;
  logic                 w_co, w_last;

  assign w_a_nib = r_opa[NIBBLE_W*r_idx +: NIBBLE_W];
  assign w_b_nib = r_opb[NIBBLE_W*r_idx +: NIBBLE_W];
  assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

  nibble_adder u_slice (
    .A   (w_a_nib),
    .B   (w_b_nib),
    .Cin (r_carry),
    .Sum (w_s_nib),
    .Cout(w_co)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b0;
    case (r_state)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) w_next = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Out_Valid = 1'b1;
        if (Out_Ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inverted operand and forced carry are captured up front.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid) begin
            r_opa   <= A;
            r_opb   <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_idx   <= '0;
          end
        end
        ADD: begin
          r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_s_nib;
          r_carry <= w_co;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= signed_ovf(r_opa[WIDTH-1], r_opb[WIDTH-1], w_s_nib[NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_rca_sequencer.sv
// Scoreboard bench for rca_sequencer: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_rca_sequencer;

  localparam int unsigned W = 16;

  logic         Clk = 1'b0;
  logic         Rst_n, In_Valid, In_Ready, Cin, Sub;
  logic         Out_Valid, Out_Ready, Cout, Overflow, Busy;
  logic [W-1:0] A, B, Sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rca_sequencer #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    longint lim, half, ua, ub, sa, sbv, ur, sr;
    exp_t   e;
    lim  = longint'(1) << W;
    half = lim >> 1;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= half) ? ua - lim : ua;
    sbv  = (ub >= half) ? ub - lim : ub;
    if (sub) begin
      ur     = ua - ub;
      sr     = sa - sbv;
      e.cout = (ua >= ub);
    end else begin
      ur     = ua + ub + longint'(cin);
      sr     = sa + sbv + longint'(cin);
      e.cout = (ur >= lim);
    end
    e.sum = ur[W-1:0];
    e.ovf = (sr > half - 1) || (sr < -half);
    return e;
  endfunction

  exp_t mon_e;
  always @(negedge Clk) begin
    if (Rst_n && Out_Valid && Out_Ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got Sum=0x%0h expected no result", Sum);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum", Sum, mon_e.sum);
        chk("cout", Cout, mon_e.cout);
        chk("ovf", Overflow, mon_e.ovf);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int guard;
    guard = 0;
    @(posedge Clk); #1;
    A = a; B = b; Cin = cin; Sub = sub; In_Valid = 1'b1;
    while (!In_Ready && guard < 50) begin
      @(posedge Clk); #1;
      guard++;
    end
    if (!In_Ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got In_Ready=0 expected 1");
      In_Valid = 1'b0;
      return;
    end
    sb_q.push_back(model(a, b, cin, sub));
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!Out_Valid && cyc < 50) begin
      @(posedge Clk); #1;
      cyc++;
    end
    if (!Out_Valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got Out_Valid=0 expected 1");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(posedge Clk); #1;
      g++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    logic [W-1:0] s0, ra, rb;
    logic         c0, o0, rc, rs;

    Rst_n = 1'b0; In_Valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; Out_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Overflow, 0);
    Rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("busy_add", Busy, 1);
    wait_valid(cyc);
    chk("latency", cyc, 4);
    drain();

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0); drain();
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1); drain();
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1); drain();
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();

    // Backpressure with a competing request held on the input side
    Out_Ready = 1'b0;
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid(cyc);
    s0 = Sum; c0 = Cout; o0 = Overflow;
    A = 16'hAAAA; B = 16'h0101; Cin = 1'b0; Sub = 1'b1; In_Valid = 1'b1;
    repeat (5) begin
      @(posedge Clk); #1;
      chk("bp_valid", Out_Valid, 1);
      chk("bp_sum", Sum, s0);
      chk("bp_cout", Cout, c0);
      chk("bp_ovf", Overflow, o0);
      chk("bp_in_ready", In_Ready, 0);
    end
    Out_Ready = 1'b1;
    sb_q.push_back(model(16'hAAAA, 16'h0101, 1'b0, 1'b1));
    @(posedge Clk); #1;
    chk("bp_idle_ready", In_Ready, 1);
    chk("bp_idle_valid", Out_Valid, 0);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    chk("bp_second_busy", Busy, 1);
    drain();

    // Reset during ADD at idx=2
    do_op(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("pre_rst_busy", Busy, 1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", Out_Valid, 0);
    chk("mid_rst_ready", In_Ready, 1);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_sum", Sum, 0);
    chk("mid_rst_cout", Cout, 0);
    sb_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (8) begin
      @(posedge Clk); #1;
      chk("post_rst_no_valid", Out_Valid, 0);
    end
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      Out_Ready = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, rs);
      if (!Out_Ready) begin
        wait_valid(cyc);
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
